// File: rtl/alu_shift_seq.sv
// Nibble-serial sequencer for CB-prefix shift/rotate ops: IDLE -> LO -> HI -> DONE.
// Define ALU_SHIFT_SEQ_QUEUE_EN to add a one-entry pending request buffer.
module alu_shift_seq (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_op,
   input  logic [7:0] req_b,
   input  logic       req_c,
   output logic       shift_dbl,
   output logic       res_valid,
   output logic [7:0] result,
   output logic       flag_z,
   output logic       flag_n,
   output logic       flag_h,
   output logic       flag_c
);

   localparam logic [2:0] OP_RLC  = 3'd0;
   localparam logic [2:0] OP_RRC  = 3'd1;
   localparam logic [2:0] OP_RL   = 3'd2;
   localparam logic [2:0] OP_RR   = 3'd3;
   localparam logic [2:0] OP_SLA  = 3'd4;
   localparam logic [2:0] OP_SRA  = 3'd5;
   localparam logic [2:0] OP_SWAP = 3'd6;
   localparam logic [2:0] OP_SRL  = 3'd7;

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t     state;
   logic [2:0] op_q;
   logic [7:0] b_q;
   logic       c_q;
   logic       dbl_q;
   logic [3:0] lo_q;
   logic [7:0] work_q;
   logic       cw_q;
   logic       zw_q;
   logic       accept;
   logic       start_new;
   logic       load_pend;
   logic       store_pend;

   function automatic logic is_right(input logic [2:0] op);
      return (op == OP_RRC) || (op == OP_RR) || (op == OP_SRA) || (op == OP_SRL);
   endfunction

   // Bit crossing the nibble boundary: b[4] moves down on right ops, b[3] moves up on left ops.
   function automatic logic dbl_bit(input logic [2:0] op, input logic [7:0] b);
      if (op == OP_SWAP) return 1'b0;
      return is_right(op) ? b[4] : b[3];
   endfunction

   function automatic logic [3:0] lo_nib(input logic [2:0] op, input logic [7:0] b,
                                         input logic c, input logic dbl);
      case (op)
         OP_RLC:  return {b[2:0], b[7]};
         OP_RL:   return {b[2:0], c};
         OP_SLA:  return {b[2:0], 1'b0};
         OP_SWAP: return b[7:4];
         default: return {dbl, b[3:1]};
      endcase
   endfunction

   function automatic logic [3:0] hi_nib(input logic [2:0] op, input logic [7:0] b,
                                         input logic c, input logic dbl);
      case (op)
         OP_RRC:  return {b[0], b[7:5]};
         OP_RR:   return {c, b[7:5]};
         OP_SRA:  return {b[7], b[7:5]};
         OP_SRL:  return {1'b0, b[7:5]};
         OP_SWAP: return b[3:0];
         default: return {b[6:4], dbl};
      endcase
   endfunction

   function automatic logic carry_out(input logic [2:0] op, input logic [7:0] b);
      if (op == OP_SWAP) return 1'b0;
      return is_right(op) ? b[0] : b[7];
   endfunction

`ifdef ALU_SHIFT_SEQ_QUEUE_EN
   logic       pending_full;
   logic [2:0] pop_q;
   logic [7:0] pb_q;
   logic       pc_q;

   assign req_ready  = !pending_full;
   assign accept     = req_valid && req_ready;
   // A request landing in DONE with an empty buffer starts straight away.
   assign start_new  = accept && ((state == IDLE) || (state == DONE));
   assign load_pend  = (state == DONE) && pending_full;
   assign store_pend = accept && ((state == LO) || (state == HI));
`else
   assign req_ready  = (state == IDLE);
   assign accept     = req_valid && req_ready;
   assign start_new  = accept;
   assign load_pend  = 1'b0;
   assign store_pend = 1'b0;
`endif

   assign shift_dbl = (state == LO) && dbl_q;
   assign flag_n    = 1'b0;
   assign flag_h    = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         res_valid <= 1'b0;
         result    <= 8'h00;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
`ifdef ALU_SHIFT_SEQ_QUEUE_EN
         pending_full <= 1'b0;
`endif
      end else begin
         res_valid <= 1'b0;
         case (state)
            IDLE: if (start_new) state <= LO;
            LO:   state <= HI;
            HI:   state <= DONE;
            DONE: begin
               res_valid <= 1'b1;
               result    <= work_q;
               flag_z    <= zw_q;
               flag_c    <= cw_q;
               state     <= (load_pend || start_new) ? LO : IDLE;
            end
            default: state <= IDLE;
         endcase
`ifdef ALU_SHIFT_SEQ_QUEUE_EN
         if (store_pend)     pending_full <= 1'b1;
         else if (load_pend) pending_full <= 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (start_new) begin
         op_q  <= req_op;
         b_q   <= req_b;
         c_q   <= req_c;
         dbl_q <= dbl_bit(req_op, req_b);
      end
`ifdef ALU_SHIFT_SEQ_QUEUE_EN
      else if (load_pend) begin
         op_q  <= pop_q;
         b_q   <= pb_q;
         c_q   <= pc_q;
         dbl_q <= dbl_bit(pop_q, pb_q);
      end
      if (store_pend) begin
         pop_q <= req_op;
         pb_q  <= req_b;
         pc_q  <= req_c;
      end
`endif
      if (state == LO) lo_q <= lo_nib(op_q, b_q, c_q, dbl_q);
      if (state == HI) begin
         work_q <= {hi_nib(op_q, b_q, c_q, dbl_q), lo_q};
         cw_q   <= carry_out(op_q, b_q);
         zw_q   <= ({hi_nib(op_q, b_q, c_q, dbl_q), lo_q} == 8'h00);
      end
   end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: directed plan cases plus randomized ops vs a plain-arithmetic model.
module tb_alu_shift_seq;
   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [7:0] req_b;
   logic       req_c;
   logic       shift_dbl;
   logic       res_valid;
   logic [7:0] result;
   logic       flag_z, flag_n, flag_h, flag_c;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_shift_seq dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_b(req_b), .req_c(req_c), .shift_dbl(shift_dbl),
      .res_valid(res_valid), .result(result), .flag_z(flag_z), .flag_n(flag_n),
      .flag_h(flag_h), .flag_c(flag_c)
   );

   // Returns {carry, result[7:0]}
   function automatic logic [8:0] ref_op(input int op, input int b, input int c);
      int r, co;
      case (op)
         0: begin r = ((b << 1) | (b >> 7)) & 255; co = (b >> 7) & 1; end
         1: begin r = (b >> 1) | ((b & 1) << 7);   co = b & 1;        end
         2: begin r = ((b << 1) | c) & 255;        co = (b >> 7) & 1; end
         3: begin r = (b >> 1) | (c << 7);         co = b & 1;        end
         4: begin r = (b << 1) & 255;              co = (b >> 7) & 1; end
         5: begin r = (b >> 1) | (b & 128);        co = b & 1;        end
         6: begin r = ((b & 15) << 4) | (b >> 4);  co = 0;            end
         default: begin r = b >> 1;                co = b & 1;        end
      endcase
      return {co[0], r[7:0]};
   endfunction

   function automatic logic ref_dbl(input int op, input int b);
      if (op == 6) return 1'b0;
      if (op == 1 || op == 3 || op == 5 || op == 7) return ((b >> 4) & 1) != 0;
      return ((b >> 3) & 1) != 0;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [7:0] b, input logic c, input bit hold);
      logic [8:0] e;
      int lat;
      int extra;
      e = ref_op(op, b, c);
      @(negedge clk);
      req_op = op; req_b = b; req_c = c; req_valid = 1'b1;
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_bad++; $display("FAIL ready_idle: got %b want 1", req_ready);
      end
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
      req_op = 3'($urandom); req_b = 8'($urandom); req_c = 1'($urandom);
      @(negedge clk);
      n_vec++;
      if (shift_dbl !== ref_dbl(op, b)) begin
         n_bad++; $display("FAIL shift_dbl op=%0d b=%h: got %b want %b", op, b, shift_dbl, ref_dbl(op, b));
      end
      n_vec++;
      if (req_ready !== 1'b0) begin
         n_bad++; $display("FAIL ready_busy: got %b want 0", req_ready);
      end
      lat = 0;
      while (res_valid !== 1'b1 && lat < 8) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      if (hold) req_valid = 1'b0;
      n_vec++;
      if (lat !== 3) begin
         n_bad++; $display("FAIL latency op=%0d: got %0d want 3", op, lat);
      end
      n_vec++;
      if (result !== e[7:0]) begin
         n_bad++; $display("FAIL result op=%0d b=%h c=%b: got %h want %h", op, b, c, result, e[7:0]);
      end
      n_vec++;
      if (flag_c !== e[8]) begin
         n_bad++; $display("FAIL flag_c op=%0d b=%h: got %b want %b", op, b, flag_c, e[8]);
      end
      n_vec++;
      if (flag_z !== (e[7:0] == 8'h00)) begin
         n_bad++; $display("FAIL flag_z op=%0d b=%h: got %b want %b", op, b, flag_z, e[7:0] == 8'h00);
      end
      n_vec++;
      if (flag_n !== 1'b0 || flag_h !== 1'b0) begin
         n_bad++; $display("FAIL flag_nh: got %b%b want 00", flag_n, flag_h);
      end
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (res_valid !== 1'b0) begin
         n_bad++; $display("FAIL pulse_width: got %b want 0", res_valid);
      end
      if (hold) begin
         extra = 0;
         for (int k = 0; k < 6; k++) begin
            @(posedge clk); @(negedge clk);
            if (res_valid === 1'b1) extra++;
         end
         n_vec++;
         if (extra !== 0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL busy_ignore: extra pulses %0d ready %b want 0 and 1", extra, req_ready);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_b = 8'h00; req_c = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (req_ready !== 1'b1 || res_valid !== 1'b0 || shift_dbl !== 1'b0) begin
         n_bad++; $display("FAIL reset_ctrl: ready %b valid %b dbl %b want 1 0 0", req_ready, res_valid, shift_dbl);
      end
      n_vec++;
      if (result !== 8'h00 || {flag_z, flag_n, flag_h, flag_c} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_data: result %h flags %b want 00 0000", result, {flag_z, flag_n, flag_h, flag_c});
      end
      reset = 1'b0;
   endtask

   task automatic test_directed();
      run_op(3'd3, 8'h01, 1'b0, 1'b0);
      run_op(3'd3, 8'h5A, 1'b1, 1'b0);
      run_op(3'd0, 8'h85, 1'b0, 1'b0);
      run_op(3'd5, 8'h8A, 1'b0, 1'b0);
      run_op(3'd7, 8'h01, 1'b0, 1'b0);
      run_op(3'd6, 8'hF0, 1'b0, 1'b0);
      run_op(3'd2, 8'h80, 1'b1, 1'b0);
      run_op(3'd4, 8'h80, 1'b0, 1'b0);
      run_op(3'd1, 8'h01, 1'b1, 1'b0);
   endtask

   task automatic test_busy_ignore();
`ifndef ALU_SHIFT_SEQ_QUEUE_EN
      run_op(3'd3, 8'h5A, 1'b1, 1'b1);
      run_op(3'd6, 8'h3C, 1'b0, 1'b1);
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++)
         run_op(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'b0);
   endtask

   task automatic test_reset_mid();
      int pulses;
      run_op(3'd0, 8'h85, 1'b0, 1'b0);
      @(negedge clk);
      req_op = 3'd3; req_b = 8'h5A; req_c = 1'b1; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (req_ready !== 1'b1 || res_valid !== 1'b0 || shift_dbl !== 1'b0) begin
         n_bad++; $display("FAIL reset_mid_ctrl: ready %b valid %b dbl %b want 1 0 0", req_ready, res_valid, shift_dbl);
      end
      n_vec++;
      if (result !== 8'h00 || flag_c !== 1'b0 || flag_z !== 1'b0) begin
         n_bad++; $display("FAIL reset_mid_data: result %h c %b z %b want 00 0 0", result, flag_c, flag_z);
      end
      reset = 1'b0;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); @(negedge clk);
         if (res_valid === 1'b1) pulses++;
      end
      n_vec++;
      if (pulses !== 0) begin
         n_bad++; $display("FAIL reset_mid_pulse: got %0d pulses want 0", pulses);
      end
   endtask

   task automatic test_back_to_back();
`ifdef ALU_SHIFT_SEQ_QUEUE_EN
      int        pk [2];
      logic [7:0] pr [2];
      logic       pc [2];
      int        np;
      np = 0;
      @(negedge clk);
      req_op = 3'd3; req_b = 8'h03; req_c = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_op = 3'd6; req_b = 8'h12; req_c = 1'b0;
      @(negedge clk);
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_bad++; $display("FAIL q_ready_lo: got %b want 1", req_ready);
      end
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (k == 1) req_valid = 1'b0;
         @(negedge clk);
         if (res_valid === 1'b1 && np < 2) begin
            pk[np] = k; pr[np] = result; pc[np] = flag_c; np++;
         end
      end
      n_vec++;
      if (np !== 2) begin
         n_bad++; $display("FAIL q_pulses: got %0d want 2", np);
      end else begin
         n_vec++;
         if (pk[0] !== 3 || pk[1] !== 6) begin
            n_bad++; $display("FAIL q_timing: got %0d,%0d want 3,6", pk[0], pk[1]);
         end
         n_vec++;
         if (pr[0] !== 8'h01 || pc[0] !== 1'b1) begin
            n_bad++; $display("FAIL q_first: got %h/%b want 01/1", pr[0], pc[0]);
         end
         n_vec++;
         if (pr[1] !== 8'h21 || pc[1] !== 1'b0) begin
            n_bad++; $display("FAIL q_second: got %h/%b want 21/0", pr[1], pc[1]);
         end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_directed();
      test_busy_ignore();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
